// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: write/read sequencer for a 3-line feature buffer.
// Counts columns and rows of the incoming pixel stream, rotates the write
// among three line banks, and flags when a full 3-row window column is
// available at the (1-cycle latency) memory outputs.
module line_buffer_ctrl #(
    parameter int AWIDTH   = 10,
    parameter int MEM_SIZE = 512
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] cfg_width,
    input  logic [AWIDTH-1:0] cfg_height,
    input  logic              start,
    input  logic              in_valid,
    output logic              busy,
    output logic              cfg_err,
    output logic              wr_en,
    output logic [1:0]        wr_bank,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [1:0]        top_bank,
    output logic [1:0]        mid_bank,
    output logic              win_valid,
    output logic [AWIDTH-1:0] win_col,
    output logic [AWIDTH-1:0] win_row,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } state_t;

    // One extra bit so MEM_SIZE itself is representable in the compare.
    localparam logic [AWIDTH:0] MAX_WIDTH = (AWIDTH+1)'(MEM_SIZE);

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] width_q;
    logic [AWIDTH-1:0] height_q;
    logic [AWIDTH-1:0] col;
    logic [AWIDTH-1:0] row;
    logic              accept;
    logic              eol;
    logic              last_pix;
    logic              cfg_legal;
    logic              start_ok;
    logic [1:0]        wr_bank_next;

    assign cfg_legal    = (cfg_width != '0) && ({1'b0, cfg_width} <= MAX_WIDTH) &&
                          (cfg_height != '0);
    assign start_ok     = (state == IDLE) && start && cfg_legal;
    assign accept       = in_valid && busy;
    assign eol          = (col == (width_q - AWIDTH'(1)));
    assign last_pix     = eol && (row == (height_q - AWIDTH'(1)));
    assign wr_bank_next = (wr_bank == 2'd2) ? 2'd0 : wr_bank + 2'd1;
    assign wr_en        = accept;
    assign wr_addr      = col;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the state-derived busy/frame_done outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (accept && last_pix) begin
                    state_next = DONE;
                end else if (accept && eol && (row == AWIDTH'(1))) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (accept && last_pix) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Config latch, column/row counters and bank rotation.  The last pixel of
    // a frame freezes everything so counters never run past the frame end.
    // Start also restores the top/mid bank assignment so every frame begins
    // from the same bank layout, whatever height the previous frame had.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_q  <= '0;
            height_q <= '0;
            col      <= '0;
            row      <= '0;
            wr_bank  <= 2'd0;
            mid_bank <= 2'd2;
            top_bank <= 2'd1;
        end else if (start_ok) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            col      <= '0;
            row      <= '0;
            wr_bank  <= 2'd0;
            mid_bank <= 2'd2;
            top_bank <= 2'd1;
        end else if (accept && !last_pix) begin
            if (eol) begin
                col      <= '0;
                row      <= row + AWIDTH'(1);
                top_bank <= mid_bank;
                mid_bank <= wr_bank;
                wr_bank  <= wr_bank_next;
            end else begin
                col <= col + AWIDTH'(1);
            end
        end
    end

    // Window flag and coordinates delayed one cycle to line up with the
    // bank read data; the error pulse is registered alongside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err   <= 1'b0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
        end else begin
            cfg_err   <= (state == IDLE) && start && !cfg_legal;
            win_valid <= accept && (state == STREAM);
            if (accept) begin
                win_col <= col;
                win_row <= row;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: scoreboard bench. Stimulus pushes expected events
// (tagged with the cycle they must appear in) into queues; a negedge monitor
// pops and compares whenever the DUT presents an output.
module tb_line_buffer_ctrl;

    localparam int AW = 10;

    typedef struct {
        int cyc;
        int addr;
        int bank;
        int top;
        int mid;
    } wr_exp_t;

    typedef struct {
        int cyc;
        int col;
        int row;
    } win_exp_t;

    typedef struct {
        int cyc;
        bit full;
        bit busy;
    } st_exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cfg_width;
    logic [AW-1:0] cfg_height;
    logic          start;
    logic          in_valid;
    logic          busy;
    logic          cfg_err;
    logic          wr_en;
    logic [1:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    logic [1:0]    top_bank;
    logic [1:0]    mid_bank;
    logic          win_valid;
    logic [AW-1:0] win_col;
    logic [AW-1:0] win_row;
    logic          frame_done;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;
    int drain_seq = 0;
    int drain_seen = 0;

    wr_exp_t  wr_q[$];
    win_exp_t win_q[$];
    st_exp_t  st_q[$];
    int       done_q[$];
    int       err_q[$];

    line_buffer_ctrl #(.AWIDTH(AW), .MEM_SIZE(512)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .start      (start),
        .in_valid   (in_valid),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .top_bank   (top_bank),
        .mid_bank   (mid_bank),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .frame_done (frame_done)
    );

    // Free-running clock and cycle counter used to tag expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output event must match the head of its queue.
    always @(negedge clk) begin
        if (wr_en) begin
            n_vec++;
            if (wr_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL wr_unexpected: cyc=%0d addr=%0d bank=%0d required=no write", cyc, wr_addr, wr_bank);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                if (e.cyc != cyc || e.addr != int'(wr_addr) || e.bank != int'(wr_bank) ||
                    e.top != int'(top_bank) || e.mid != int'(mid_bank)) begin
                    n_miss++;
                    $display("[TB] FAIL wr: got cyc=%0d addr=%0d bank=%0d top=%0d mid=%0d required cyc=%0d addr=%0d bank=%0d top=%0d mid=%0d",
                             cyc, wr_addr, wr_bank, top_bank, mid_bank, e.cyc, e.addr, e.bank, e.top, e.mid);
                end
            end
        end
        if (win_valid) begin
            n_vec++;
            if (win_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL win_unexpected: cyc=%0d col=%0d row=%0d required=no window", cyc, win_col, win_row);
            end else begin
                win_exp_t w;
                w = win_q.pop_front();
                if (w.cyc != cyc || w.col != int'(win_col) || w.row != int'(win_row)) begin
                    n_miss++;
                    $display("[TB] FAIL win: got cyc=%0d col=%0d row=%0d required cyc=%0d col=%0d row=%0d",
                             cyc, win_col, win_row, w.cyc, w.col, w.row);
                end
            end
        end
        if (frame_done) begin
            n_vec++;
            if (done_q.size() == 0 || done_q[0] != cyc) begin
                n_miss++;
                $display("[TB] FAIL frame_done: got pulse at cyc=%0d required cyc=%0d", cyc,
                         (done_q.size() == 0) ? -1 : done_q[0]);
            end
            if (done_q.size() != 0) void'(done_q.pop_front());
        end
        if (cfg_err) begin
            n_vec++;
            if (err_q.size() == 0 || err_q[0] != cyc) begin
                n_miss++;
                $display("[TB] FAIL cfg_err: got pulse at cyc=%0d required cyc=%0d", cyc,
                         (err_q.size() == 0) ? -1 : err_q[0]);
            end
            if (err_q.size() != 0) void'(err_q.pop_front());
        end
        while (st_q.size() != 0 && st_q[0].cyc <= cyc) begin
            st_exp_t s;
            s = st_q.pop_front();
            n_vec++;
            if (s.cyc != cyc) begin
                n_miss++;
                $display("[TB] FAIL state_missed: check for cyc=%0d seen at cyc=%0d", s.cyc, cyc);
            end else if (s.full) begin
                if (busy || cfg_err || wr_en || win_valid || frame_done || wr_addr != '0 ||
                    win_col != '0 || win_row != '0 || wr_bank != 2'd0 || mid_bank != 2'd2 ||
                    top_bank != 2'd1) begin
                    n_miss++;
                    $display("[TB] FAIL reset_state: got busy=%0b err=%0b wr_en=%0b winv=%0b done=%0b addr=%0d wcol=%0d wrow=%0d wb=%0d mb=%0d tb=%0d required 0,0,0,0,0,0,0,0,0,2,1",
                             busy, cfg_err, wr_en, win_valid, frame_done, wr_addr, win_col, win_row,
                             wr_bank, mid_bank, top_bank);
                end
            end else if (busy != s.busy) begin
                n_miss++;
                $display("[TB] FAIL busy: got %0b at cyc=%0d required %0b", busy, cyc, s.busy);
            end
        end
        if (drain_seq != drain_seen) begin
            drain_seen = drain_seq;
            n_vec++;
            if (wr_q.size() + win_q.size() + done_q.size() + err_q.size() + st_q.size() != 0) begin
                n_miss++;
                $display("[TB] FAIL drain: pending wr=%0d win=%0d done=%0d err=%0d st=%0d required all 0",
                         wr_q.size(), win_q.size(), done_q.size(), err_q.size(), st_q.size());
            end
        end
    end

    task automatic push_busy(input int c, input bit b);
        st_exp_t s;
        s.cyc  = c;
        s.full = 1'b0;
        s.busy = b;
        st_q.push_back(s);
    endtask

    task automatic push_reset_state(input int c);
        st_exp_t s;
        s.cyc  = c;
        s.full = 1'b1;
        s.busy = 1'b0;
        st_q.push_back(s);
    endtask

    // Idle a few cycles and ask the monitor to confirm nothing is pending.
    task automatic check_output();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drain_seq++;
        @(posedge clk);
        #1;
    endtask

    // Run one frame. Row r always writes bank r%3 with mid=(r+2)%3 and
    // top=(r+1)%3, since each frame starts from wr=0, mid=2, top=1.
    task automatic apply_stimulus(input int w, input int h, input bit toggle,
                                  input int abort_at, input int restart_at);
        int n;
        int c;
        wr_exp_t  e;
        win_exp_t wv;
        n = w * h;
        @(posedge clk);
        #1;
        cfg_width  = AW'(w);
        cfg_height = AW'(h);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (toggle && k > 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            if (k == restart_at) begin
                start      = 1'b1;
                cfg_width  = AW'(2);
                cfg_height = AW'(2);
            end
            c      = cyc;
            e.cyc  = c;
            e.addr = k % w;
            e.bank = (k / w) % 3;
            e.mid  = ((k / w) + 2) % 3;
            e.top  = ((k / w) + 1) % 3;
            wr_q.push_back(e);
            if (k == 0) push_busy(c, 1'b1);
            if (k / w >= 2) begin
                wv.cyc = c + 1;
                wv.col = k % w;
                wv.row = k / w;
                win_q.push_back(wv);
            end
            if (k == n - 1) begin
                done_q.push_back(c + 1);
                push_busy(c + 1, 1'b0);
                push_busy(c + 2, 1'b0);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == abort_at) begin
                in_valid = 1'b0;
                reset_n  = 1'b0;
                #1;
                push_reset_state(cyc);
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                push_reset_state(cyc);
                break;
            end
        end
        check_output();
    endtask

    task automatic try_illegal(input int w, input int h);
        int c;
        @(posedge clk);
        #1;
        cfg_width  = AW'(w);
        cfg_height = AW'(h);
        start      = 1'b1;
        c          = cyc;
        err_q.push_back(c + 1);
        push_busy(c + 1, 1'b0);
        push_busy(c + 2, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output();
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        cfg_width  = '0;
        cfg_height = '0;
        repeat (2) @(posedge clk);
        #1;
        push_reset_state(cyc);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        // in_valid while idle must not write
        in_valid = 1'b1;
        push_reset_state(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_output();

        $display("[TB] 4x4 continuous frame");
        apply_stimulus(4, 4, 1'b0, -1, -1);
        $display("[TB] 4x4 frame with gaps");
        apply_stimulus(4, 4, 1'b1, -1, -1);
        $display("[TB] illegal configurations");
        try_illegal(0, 4);
        try_illegal(513, 4);
        try_illegal(4, 0);
        $display("[TB] 1x2 short frame");
        apply_stimulus(1, 2, 1'b0, -1, -1);
        $display("[TB] 3x3 frame");
        apply_stimulus(3, 3, 1'b0, -1, -1);
        $display("[TB] reset after pixel 6, then clean frame");
        apply_stimulus(4, 4, 1'b0, 6, -1);
        apply_stimulus(4, 4, 1'b0, -1, -1);
        $display("[TB] start during busy");
        apply_stimulus(4, 4, 1'b0, -1, 5);
        $display("[TB] maximum width, single row");
        apply_stimulus(512, 1, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
